// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter slice.
//   DEF_XLEN / DEF_AW : default data and register-index widths
//   REG_ZERO          : architectural zero register index (writes suppressed)
//   rr_next()         : round-robin pointer update after a grant
package regfile_wb_pkg;

    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned DEF_AW   = 5;
    localparam int unsigned REG_ZERO = 0;

    // Next pointer after granting index i out of n requesters. An index
    // outside the requester range means "no grant" and keeps ptr.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input int unsigned i,
                                            input int unsigned n);
        if (i >= n)
            return ptr;
        return (i + 1 == n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester-side valid/ready bundle of the writeback arbiter.
//   req_valid [NUM_REQ]       : requester i has a write pending
//   req_rd    [NUM_REQ*AW]    : destination index, slice i = [i*AW +: AW]
//   req_data  [NUM_REQ*XLEN]  : write value, slice i = [i*XLEN +: XLEN]
//   req_ready [NUM_REQ]       : one-hot grant back to the requesters
// master = writeback sources, slave = arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 5
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*AW-1:0]   req_rd;
    logic [NUM_REQ*XLEN-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;

    modport master (output req_valid, output req_rd, output req_data, input req_ready);
    modport slave  (input req_valid, input req_rd, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter_onehot.sv
// Combinational round-robin arbiter.
//   valid   : request vector
//   ptr     : index with highest priority this cycle (0..NUM_REQ-1)
//   grant   : one-hot grant of the first valid index at or after ptr (wrapping)
//   gnt_idx : binary index of the granted requester
//   gnt_any : some requester was granted
module rr_arbiter_onehot #(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        int unsigned idx;
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!gnt_any && valid[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = PW'(idx);
                gnt_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between NUM_REQ writeback
// sources with round-robin arbitration and one output stage register.
//   clk, reset (sync, active-high)
//   hold       : suppress grants; the stage still drains
//   wb         : requester valid/rd/data/ready bundle (slave side)
//   reg_write, write_reg, write_data : register-file write port
//   busy       : stage holds an accepted write (including x0) this cycle
// Optional macro WB_BYPASS_EN adds byp_rs1/2 inputs and byp_hit1/2,
// byp_data1/2 outputs forwarding the staged write.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned XLEN    = DEF_XLEN,
    parameter int unsigned AW      = DEF_AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    regfile_wb_arbiter_if.slave  wb,
    output logic                 reg_write,
    output logic [AW-1:0]        write_reg,
    output logic [XLEN-1:0]      write_data,
    output logic                 busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0]        byp_rs1,
    input  logic [AW-1:0]        byp_rs2,
    output logic                 byp_hit1,
    output logic                 byp_hit2,
    output logic [XLEN-1:0]      byp_data1,
    output logic [XLEN-1:0]      byp_data2
`endif
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [AW-1:0]      sel_rd;
    logic [XLEN-1:0]    sel_data;

    // Gating the request vector makes hold/reset force req_ready low.
    rr_arbiter_onehot #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid   (wb.req_valid & {NUM_REQ{~hold & ~reset}}),
        .ptr     (ptr),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign wb.req_ready = grant;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = wb.req_rd[i*AW +: AW];
                sel_data = wb.req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            reg_write  <= 1'b0;
            busy       <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (gnt_any) begin
            ptr        <= PW'(rr_next(32'(ptr), 32'(gnt_idx), NUM_REQ));
            busy       <= 1'b1;
            reg_write  <= (sel_rd != AW'(REG_ZERO));
            write_reg  <= sel_rd;
            write_data <= sel_data;
        end else begin
            reg_write  <= 1'b0;
            busy       <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_hit1  = reg_write && (write_reg == byp_rs1) && (byp_rs1 != AW'(REG_ZERO));
    assign byp_hit2  = reg_write && (write_reg == byp_rs2) && (byp_rs2 != AW'(REG_ZERO));
    assign byp_data1 = byp_hit1 ? write_data : '0;
    assign byp_data2 = byp_hit2 ? write_data : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int N    = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic reset;
    logic hold;
    logic reg_write;
    logic [AW-1:0]   write_reg;
    logic [XLEN-1:0] write_data;
    logic busy;
`ifdef WB_BYPASS_EN
    logic [AW-1:0]   byp_rs1, byp_rs2;
    logic            byp_hit1, byp_hit2;
    logic [XLEN-1:0] byp_data1, byp_data2;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(N), .XLEN(XLEN), .AW(AW)) wb ();

    regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .wb         (wb.slave),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .busy       (busy)
`ifdef WB_BYPASS_EN
        ,
        .byp_rs1    (byp_rs1),
        .byp_rs2    (byp_rs2),
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
        .byp_data1  (byp_data1),
        .byp_data2  (byp_data2)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus per requester
    logic            s_valid [N];
    logic [AW-1:0]   s_rd    [N];
    logic [XLEN-1:0] s_data  [N];
    logic            s_hold;
    logic            s_reset;

    // Reference model: pointer plus the staged write
    int              m_ptr;
    logic            m_busy, m_we, m_known;
    logic [AW-1:0]   m_reg;
    logic [XLEN-1:0] m_data;
    int              last_grant;

    function automatic int model_grant();
        if (s_hold || s_reset)
            return -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (s_valid[idx])
                return idx;
        end
        return -1;
    endfunction

    task automatic step(input string tag);
        int eg;
        logic [N-1:0] exp_ready;
        hold  = s_hold;
        reset = s_reset;
        for (int i = 0; i < N; i++) begin
            wb.req_valid[i]             = s_valid[i];
            wb.req_rd[i*AW +: AW]       = s_rd[i];
            wb.req_data[i*XLEN +: XLEN] = s_data[i];
        end
        #1;
        eg = model_grant();
        exp_ready = '0;
        if (eg >= 0)
            exp_ready[eg] = 1'b1;
        check({tag, ".ready"}, 64'(wb.req_ready), 64'(exp_ready));
        last_grant = eg;
        @(posedge clk);
        if (s_reset) begin
            m_ptr = 0; m_busy = 0; m_we = 0; m_reg = '0; m_data = '0; m_known = 1;
        end else if (eg >= 0) begin
            m_busy  = 1;
            m_we    = (s_rd[eg] != 0);
            m_reg   = s_rd[eg];
            m_data  = s_data[eg];
            m_known = 1;
            m_ptr   = (eg + 1) % N;
        end else begin
            m_busy = 0; m_we = 0; m_known = 0;
        end
        #1;
        check({tag, ".busy"}, 64'(busy), 64'(m_busy));
        check({tag, ".reg_write"}, 64'(reg_write), 64'(m_we));
        if (m_known) begin
            check({tag, ".write_reg"}, 64'(write_reg), 64'(m_reg));
            check({tag, ".write_data"}, 64'(write_data), 64'(m_data));
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            s_valid[i] = 0; s_rd[i] = '0; s_data[i] = '0;
        end
    endtask

    initial begin
        int rr_exp [6];
        rr_exp = '{0, 1, 2, 0, 1, 2};
        m_ptr = 0; m_busy = 0; m_we = 0; m_known = 0; m_reg = '0; m_data = '0;
        last_grant = -1;
        s_hold = 0;
        s_reset = 1;
        clear_reqs();
`ifdef WB_BYPASS_EN
        byp_rs1 = '0; byp_rs2 = '0;
`endif

        // Reset with a request pending: no grant, clean stage
        s_valid[0] = 1; s_rd[0] = 5'd7; s_data[0] = 32'hAAAA_0000;
        step("reset0");
        step("reset1");
        s_reset = 0;
        clear_reqs();

        // Round-robin with all requesters continuously valid
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) begin
                s_valid[i] = 1;
                s_rd[i]    = AW'(i + 1);
                s_data[i]  = 32'h1000_0000 + 32'(c * 16 + i);
            end
            step("rr");
            check("rr.order", 64'(last_grant), 64'(rr_exp[c]));
        end
        clear_reqs();

        // Single request on requester 0
        s_valid[0] = 1; s_rd[0] = 5'd10; s_data[0] = 32'hDEAD_BEEF;
        step("single");
        check("single.order", 64'(last_grant), 64'd0);
        clear_reqs();
        step("idle");

        // x0 write from requester 1: accepted, busy but no reg_write
        s_valid[1] = 1; s_rd[1] = '0; s_data[1] = 32'h1234;
        step("x0");
        check("x0.busy", 64'(busy), 64'd1);
        check("x0.we", 64'(reg_write), 64'd0);
        clear_reqs();

        // Hold with everyone valid: no grants, pointer kept (now 2)
        for (int i = 0; i < N; i++) begin
            s_valid[i] = 1; s_rd[i] = AW'(20 + i); s_data[i] = 32'hC0DE_0000 + 32'(i);
        end
        s_hold = 1;
        for (int c = 0; c < 3; c++) step("hold");
        s_hold = 0;
        step("release");
        check("release.order", 64'(last_grant), 64'd2);
        clear_reqs();

        // Reset in the same cycle as a request: write is discarded
        s_valid[2] = 1; s_rd[2] = 5'd9; s_data[2] = 32'h9999_9999;
        s_reset = 1;
        step("rst_mid");
        s_reset = 0;
        clear_reqs();
        step("rst_after");

`ifdef WB_BYPASS_EN
        s_valid[0] = 1; s_rd[0] = 5'd5; s_data[0] = 32'h55;
        step("byp_load");
        clear_reqs();
        byp_rs1 = 5'd5; byp_rs2 = 5'd0;
        #1;
        check("byp.hit1", 64'(byp_hit1), 64'd1);
        check("byp.data1", 64'(byp_data1), 64'h55);
        check("byp.hit2", 64'(byp_hit2), 64'd0);
        check("byp.data2", 64'(byp_data2), 64'd0);
`endif

        // Randomized traffic; requesters keep rd/data stable until granted
        clear_reqs();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!s_valid[i] && ($urandom_range(0, 2) != 0)) begin
                    s_valid[i] = 1;
                    s_rd[i]    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
                    s_data[i]  = $urandom;
                end
            end
            s_hold  = ($urandom_range(0, 7) == 0);
            s_reset = ($urandom_range(0, 49) == 0);
            step("rand");
            if (last_grant >= 0)
                s_valid[last_grant] = 0;
`ifdef WB_BYPASS_EN
            byp_rs1 = ($urandom_range(0, 1) == 0) ? m_reg : AW'($urandom);
            byp_rs2 = AW'($urandom);
            #1;
            check("rand.hit1", 64'(byp_hit1), 64'(m_we && m_reg == byp_rs1 && byp_rs1 != 0));
            check("rand.data1", 64'(byp_data1),
                  64'((m_we && m_reg == byp_rs1 && byp_rs1 != 0) ? m_data : 32'd0));
            check("rand.hit2", 64'(byp_hit2), 64'(m_we && m_reg == byp_rs2 && byp_rs2 != 0));
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
